// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - MIPS control decode carried through ID/EX, EX/MEM, MEM/WB
// with load-use stall generation and branch flush.
module pipelined_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int REG_W    = 5,
  parameter int ALUOP_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                flush,
  output logic                stall,
  output logic                ex_reg_dst,
  output logic                ex_alu_src,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic [REG_W-1:0]    ex_rt,
  output logic                ex_illegal,
  output logic                mem_branch,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic                wb_mem_to_reg,
  output logic                wb_reg_write
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2'b10);

  logic               dec_reg_dst, dec_alu_src, dec_branch, dec_mem_read;
  logic               dec_mem_write, dec_mem_to_reg, dec_reg_write, dec_illegal;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               uses_rt;

  logic ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic mem_mem_to_reg, mem_reg_write;

  always_comb begin
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_write  = 1'b0;
    dec_illegal    = 1'b0;
    dec_alu_op     = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        dec_reg_dst   = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_op    = ALU_FN;
      end
      OP_LW: begin
        dec_alu_src    = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_read   = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
        dec_alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign uses_rt = (opcode == OP_RTYPE) | (opcode == OP_SW) | (opcode == OP_BEQ);

  // Flush wins over the hazard so a squashed consumer never holds fetch.
  assign stall = ex_mem_read & (ex_rt != '0)
               & ((ex_rt == id_rs) | ((ex_rt == id_rt) & uses_rt))
               & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      ex_rt         <= '0;
      ex_illegal    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
    end else if (flush || stall) begin
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      ex_rt         <= '0;
      ex_illegal    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
    end else begin
      ex_reg_dst    <= dec_reg_dst;
      ex_alu_src    <= dec_alu_src;
      ex_alu_op     <= dec_alu_op;
      ex_rt         <= id_rt;
      ex_illegal    <= dec_illegal;
      ex_branch     <= dec_branch;
      ex_mem_read   <= dec_mem_read;
      ex_mem_write  <= dec_mem_write;
      ex_mem_to_reg <= dec_mem_to_reg;
      ex_reg_write  <= dec_reg_write;
    end
  end

  // A stall bubbles only ID/EX; the older instructions keep draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_branch     <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_reg_write  <= 1'b0;
    end else if (flush) begin
      mem_branch     <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_reg_write  <= 1'b0;
    end else begin
      mem_branch     <= ex_branch;
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_reg_write  <= ex_reg_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
    end else begin
      wb_mem_to_reg <= mem_mem_to_reg;
      wb_reg_write  <= mem_reg_write;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - self-checking bench for pipelined_control_unit
// against an instruction-level pipeline reference model.
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [4:0] id_rs, id_rt;
  logic       flush;
  logic       stall;
  logic       ex_reg_dst, ex_alu_src, ex_illegal;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rt;
  logic       mem_branch, mem_mem_read, mem_mem_write;
  logic       wb_mem_to_reg, wb_reg_write;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, ILL = 6'b111111;

  pipelined_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .stall(stall),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_rt(ex_rt), .ex_illegal(ex_illegal),
    .mem_branch(mem_branch), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write)
  );

  always #5 clk = ~clk;

  // One in-flight instruction as the reference model sees it.
  typedef struct packed {
    logic       reg_dst, alu_src;
    logic [1:0] alu_op;
    logic       branch, mem_read, mem_write, mem_to_reg, reg_write, illegal;
    logic [4:0] rt;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;

  function automatic instr_t describe(input logic [5:0] op, input logic [4:0] rt);
    instr_t d = '0;
    d.rt = rt;
    if (op == R)         begin d.reg_dst = 1; d.reg_write = 1; d.alu_op = 2; end
    else if (op == LW)   begin d.alu_src = 1; d.mem_to_reg = 1; d.reg_write = 1; d.mem_read = 1; end
    else if (op == SW)   begin d.alu_src = 1; d.mem_write = 1; end
    else if (op == BEQ)  begin d.branch = 1; d.alu_op = 1; end
    else if (op == ADDI) begin d.alu_src = 1; d.reg_write = 1; end
    else                 d.illegal = 1;
    return d;
  endfunction

  function automatic logic model_stall();
    logic reads_rt = (opcode == R) || (opcode == SW) || (opcode == BEQ);
    return m_ex.mem_read && m_ex.rt != 0 &&
           (m_ex.rt == id_rs || (m_ex.rt == id_rt && reads_rt)) && !flush;
  endfunction

  function automatic logic [14:0] model_outs();
    return {m_ex.reg_dst, m_ex.alu_src, m_ex.alu_op, m_ex.rt, m_ex.illegal,
            m_mem.branch, m_mem.mem_read, m_mem.mem_write, m_wb.mem_to_reg, m_wb.reg_write};
  endfunction

  function automatic logic [14:0] dut_outs();
    return {ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, ex_illegal,
            mem_branch, mem_mem_read, mem_mem_write, wb_mem_to_reg, wb_reg_write};
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
  endtask

  task automatic apply(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic fl);
    opcode = op; id_rs = rs; id_rt = rt; flush = fl;
    #1;
  endtask

  // Advance one clock edge and the model in step with it.
  task automatic tick();
    instr_t nxt_ex;
    logic   st = model_stall();
    nxt_ex = (flush || st) ? '0 : describe(opcode, id_rt);
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = flush ? '0 : m_ex;
    m_ex  = nxt_ex;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(LW, 5'd5, 5'd5, 1'b0);
    @(posedge clk); #1;
    model_reset();
    tests++;
    if (dut_outs() !== 15'd0 || stall !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got %h/%b want 0/0", dut_outs(), stall);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    apply(LW, 5'd0, 5'd0, 1'b0);
    tick();
    tests++;
    if (ex_alu_src !== 1'b1) begin fails++; $display("FAIL lat_ex_alu_src: got %b want 1", ex_alu_src); end
    apply(ADDI, 5'd0, 5'd0, 1'b0);
    tick();
    tests++;
    if (mem_mem_read !== 1'b1) begin fails++; $display("FAIL lat_mem_read: got %b want 1", mem_mem_read); end
    tick();
    tests++;
    if ({wb_mem_to_reg, wb_reg_write} !== 2'b11) begin
      fails++; $display("FAIL lat_wb: got %b want 11", {wb_mem_to_reg, wb_reg_write});
    end
    // Asynchronous clear in mid-cycle, away from any clock edge.
    apply(SW, 5'd1, 5'd2, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if (dut_outs() !== 15'd0) begin fails++; $display("FAIL async_reset: got %h want 0", dut_outs()); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    apply(LW, 5'd1, 5'd5, 1'b0);
    tick();
    apply(R, 5'd5, 5'd9, 1'b0);
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall: got %b want 1", stall); end
    tick();
    tests++;
    if ({ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, ex_illegal} !== 10'd0 || stall !== 1'b0) begin
      fails++; $display("FAIL load_use_bubble: ex=%h stall=%b want 0/0",
                        {ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, ex_illegal}, stall);
    end
    tick();
    tests++;
    if (ex_reg_dst !== 1'b1 || ex_alu_op !== 2'b10) begin
      fails++; $display("FAIL load_use_resume: got %b/%b want 1/10", ex_reg_dst, ex_alu_op);
    end
  endtask

  task automatic test_no_hazard();
    apply(LW, 5'd0, 5'd0, 1'b0);
    tick();
    apply(R, 5'd0, 5'd0, 1'b0);
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL no_hazard_rt0: got %b want 0", stall); end
    tick();
    apply(LW, 5'd0, 5'd5, 1'b0);
    tick();
    apply(ADDI, 5'd3, 5'd5, 1'b0);
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL no_hazard_addi: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_flush();
    apply(ADDI, 5'd1, 5'd2, 1'b0);
    tick();
    apply(SW, 5'd3, 5'd4, 1'b0);
    tick();
    apply(BEQ, 5'd1, 5'd2, 1'b1);
    tick();
    tests++;
    if ({ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, ex_illegal} !== 10'd0 || mem_mem_write !== 1'b0) begin
      fails++; $display("FAIL flush_squash: ex=%h mem_write=%b want 0/0",
                        {ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, ex_illegal}, mem_mem_write);
    end
    tests++;
    if (wb_reg_write !== 1'b1) begin fails++; $display("FAIL flush_wb_addi: got %b want 1", wb_reg_write); end
    apply(ADDI, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_illegal();
    apply(ILL, 5'd0, 5'd0, 1'b0);
    tick();
    tests++;
    if ({ex_reg_dst, ex_alu_src, ex_alu_op, ex_illegal} !== 5'b00001) begin
      fails++; $display("FAIL illegal_ex: got %b want 00001", {ex_reg_dst, ex_alu_src, ex_alu_op, ex_illegal});
    end
    apply(ADDI, 5'd0, 5'd0, 1'b0);
    tick();
    tests++;
    if (ex_illegal !== 1'b0) begin fails++; $display("FAIL illegal_clear: got %b want 0", ex_illegal); end
    tests++;
    if (mem_mem_read !== 1'b0 || mem_mem_write !== 1'b0 || mem_branch !== 1'b0) begin
      fails++; $display("FAIL illegal_mem: got %b want 000", {mem_branch, mem_mem_read, mem_mem_write});
    end
  endtask

  task automatic test_flush_stall();
    apply(LW, 5'd0, 5'd7, 1'b0);
    tick();
    apply(R, 5'd7, 5'd0, 1'b1);
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall_comb: got %b want 0", stall); end
    tick();
    tests++;
    if ({ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, ex_illegal, mem_branch, mem_mem_read, mem_mem_write} !== 13'd0) begin
      fails++; $display("FAIL flush_stall_zero: got %h want 0",
                        {ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, ex_illegal, mem_branch, mem_mem_read, mem_mem_write});
    end
    apply(ADDI, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops[0] = R; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = ADDI; ops[5] = ILL;
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      apply(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
      tests++;
      if (stall !== model_stall()) begin
        fails++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall, model_stall());
      end
      tick();
      tests++;
      if (dut_outs() !== model_outs()) begin
        fails++; $display("FAIL rand_outs[%0d]: got %h want %h", i, dut_outs(), model_outs());
      end
    end
  endtask

  initial begin
    rst = 1'b1; opcode = '0; id_rs = '0; id_rt = '0; flush = 1'b0;
    model_reset();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_illegal();
    test_flush_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
